// File: rtl/gpio_board_bridge.sv
// gpio_board_bridge: board-side end of the CPU GPIO port.
// Converts the CPU output word to decimal for eight active-low seven-segment
// digits (with an overflow LED) and returns the synchronized board switches.
module gpio_board_bridge #(
  parameter int unsigned SW_WIDTH      = 18,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         gpio_out_i,
  input  logic [SW_WIDTH-1:0] sw,
  output logic [31:0]         gpio_in_o,
  output logic [55:0]         hex,
  output logic                ovf,
  output logic                busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BCD_W  = 40;
  localparam int unsigned NDIG   = 8;
  localparam int unsigned NNIB   = 10;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned CNT_W  = 5;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                   state_q;
  logic [SW_WIDTH-1:0]      sync1_q, sync2_q;
  logic [DATA_W-1:0]        last_val_q, bin_q;
  logic [BCD_W-1:0]         bcd_q, bcd_adj;
  logic [CNT_W-1:0]         count_q;
  logic [NDIG*SEG_W-1:0]    hex_q, hex_d;
  logic [BCD_W+DATA_W-1:0]  shift_d;
  logic                     ovf_q, ovf_d, busy_q;

  // Digit value to active-low segments, bit order g..a
  function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble step: add 3 to every nibble >= 5, then shift {bcd,bin} left
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < int'(NNIB); k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
    shift_d = {bcd_adj, bin_q} << 1;
  end

  // Segment image of the finished conversion, leading zeros blanked from digit 7 down
  always_comb begin : decode_blk
    logic run;
    hex_d = '0;
    run   = BLANK_LEADING;
    for (int i = int'(NDIG) - 1; i >= 0; i--) begin
      if (run && (i != 0) && (bcd_q[4*i +: 4] == 4'd0)) begin
        hex_d[SEG_W*i +: SEG_W] = SEG_BLANK;
      end else begin
        hex_d[SEG_W*i +: SEG_W] = seg_decode(bcd_q[4*i +: 4]);
        run = 1'b0;
      end
    end
    ovf_d = |bcd_q[BCD_W-1:32];
  end

  // Two-flop switch synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
    end
  end

  // Conversion FSM with registered display, overflow and busy outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_val_q <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      count_q    <= '0;
      hex_q      <= {{(NDIG-1){SEG_BLANK}}, SEG_ZERO};
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gpio_out_i != last_val_q) begin
            bin_q      <= gpio_out_i;
            last_val_q <= gpio_out_i;
            bcd_q      <= '0;
            count_q    <= '0;
            state_q    <= SHIFT;
            busy_q     <= 1'b1;
          end
        end
        SHIFT: begin
          bcd_q   <= shift_d[BCD_W+DATA_W-1:DATA_W];
          bin_q   <= shift_d[DATA_W-1:0];
          count_q <= count_q + CNT_W'(1);
          if (count_q == CNT_W'(31)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          hex_q   <= hex_d;
          ovf_q   <= ovf_d;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gpio_in_o = DATA_W'(sync2_q);
  assign hex       = hex_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule
